// File: rtl/freq_meas_sequencer.sv
// Sequences a single shared frequency counter across NUM_CH mux-selected signals:
// select, settle with counter cleared, gate for GATE_CYCLES, then capture and report.
module freq_meas_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int CH_W          = 2,
    parameter int CNT_W         = 32,
    parameter int GATE_CYCLES   = 100000000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Continuous,
    input  logic [NUM_CH-1:0] ChanMask,
    output logic [CH_W-1:0]   SigSel,
    output logic              CntClr,
    output logic              CntEn,
    input  logic [CNT_W-1:0]  CntVal,
    output logic              Busy,
    output logic              ResultValid,
    output logic [CH_W-1:0]   ResultChan,
    output logic [CNT_W-1:0]  ResultFreq
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        GATE    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t              state_r;
    logic [NUM_CH-1:0]   mask_r;
    logic [31:0]         timer_r;
    logic                low_found_s;
    logic [CH_W-1:0]     low_ch_s;
    logic                next_found_s;
    logic [CH_W-1:0]     next_ch_s;

    // Channel search: lowest set bit of the live mask, next set bit above SigSel in the latched mask
    always_comb begin
        low_found_s  = 1'b0;
        low_ch_s     = {CH_W{1'b0}};
        next_found_s = 1'b0;
        next_ch_s    = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            low_found_s  = ChanMask[i] ? 1'b1 : low_found_s;
            low_ch_s     = ChanMask[i] ? CH_W'(i) : low_ch_s;
            next_found_s = (mask_r[i] && (i > int'(SigSel))) ? 1'b1 : next_found_s;
            next_ch_s    = (mask_r[i] && (i > int'(SigSel))) ? CH_W'(i) : next_ch_s;
        end
    end

    // Sequencer state machine with all outputs registered
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= IDLE;
            mask_r      <= {NUM_CH{1'b0}};
            timer_r     <= 32'd0;
            SigSel      <= {CH_W{1'b0}};
            CntClr      <= 1'b1;
            CntEn       <= 1'b0;
            Busy        <= 1'b0;
            ResultValid <= 1'b0;
            ResultChan  <= {CH_W{1'b0}};
            ResultFreq  <= {CNT_W{1'b0}};
        end else begin
            ResultValid <= 1'b0;
            if (Stop) begin
                state_r <= IDLE;
                CntClr  <= 1'b1;
                CntEn   <= 1'b0;
                Busy    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        CntClr <= 1'b1;
                        CntEn  <= 1'b0;
                        if (Start && low_found_s) begin
                            mask_r  <= ChanMask;
                            SigSel  <= low_ch_s;
                            Busy    <= 1'b1;
                            state_r <= SELECT;
                        end else begin
                            Busy <= 1'b0;
                        end
                    end
                    SELECT: begin
                        CntClr  <= 1'b1;
                        CntEn   <= 1'b0;
                        timer_r <= 32'(SETTLE_CYCLES - 1);
                        state_r <= SETTLE;
                    end
                    SETTLE: begin
                        if (timer_r == 32'd0) begin
                            CntClr  <= 1'b0;
                            CntEn   <= 1'b1;
                            timer_r <= 32'(GATE_CYCLES - 1);
                            state_r <= GATE;
                        end else begin
                            timer_r <= timer_r - 32'd1;
                        end
                    end
                    GATE: begin
                        if (timer_r == 32'd0) begin
                            CntEn   <= 1'b0;
                            state_r <= CAPTURE;
                        end else begin
                            timer_r <= timer_r - 32'd1;
                        end
                    end
                    CAPTURE: begin
                        ResultFreq  <= CntVal;
                        ResultChan  <= SigSel;
                        ResultValid <= 1'b1;
                        CntClr      <= 1'b1;
                        CntEn       <= 1'b0;
                        if (next_found_s) begin
                            SigSel  <= next_ch_s;
                            state_r <= SELECT;
                        end else if (Continuous && low_found_s) begin
                            // Continuous sweeps pick up the mask as it stands now
                            mask_r  <= ChanMask;
                            SigSel  <= low_ch_s;
                            state_r <= SELECT;
                        end else begin
                            Busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        CntClr  <= 1'b1;
                        CntEn   <= 1'b0;
                        Busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Randomized self-checking bench for freq_meas_sequencer, with a behavioural
// counter and a transaction-level prediction of strobe timing, channels and gate windows.
module tb_freq_meas_sequencer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 32;
    localparam int G      = 10;
    localparam int S      = 2;
    localparam int LAT    = 3 + S + G;
    localparam int SPACE  = 2 + S + G;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Start;
    logic              Stop;
    logic              Continuous;
    logic [NUM_CH-1:0] ChanMask;
    logic [CH_W-1:0]   SigSel;
    logic              CntClr;
    logic              CntEn;
    logic [CNT_W-1:0]  CntVal;
    logic              Busy;
    logic              ResultValid;
    logic [CH_W-1:0]   ResultChan;
    logic [CNT_W-1:0]  ResultFreq;

    always #5 Clk = ~Clk;

    freq_meas_sequencer #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W),
        .GATE_CYCLES(G), .SETTLE_CYCLES(S)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Continuous(Continuous),
        .ChanMask(ChanMask), .SigSel(SigSel), .CntClr(CntClr), .CntEn(CntEn),
        .CntVal(CntVal), .Busy(Busy), .ResultValid(ResultValid),
        .ResultChan(ResultChan), .ResultFreq(ResultFreq)
    );

    // Edge counter in the datapath: clears on CntClr, counts on CntEn
    logic [CNT_W-1:0] cnt = 32'd0;
    always @(posedge Clk) begin
        if (CntClr) cnt <= 32'd0;
        else if (CntEn) cnt <= cnt + 32'd1;
    end
    assign CntVal = cnt;

    typedef struct {
        int cyc;
        int chan;
        int freq;
        int busy;
    } strobe_t;

    strobe_t sq[$];
    int      gate_q[$];
    int      clr_q[$];
    int      sel_q[$];
    int      en_run  = 0;
    int      clr_run = 0;
    logic    en_prev = 1'b0;
    int      cyc     = 0;
    int      n_chk   = 0;
    int      n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // One clock: advance past the edge, then observe outputs
    task automatic tick();
        @(posedge Clk);
        #2;
        cyc++;
        if (ResultValid === 1'b1)
            sq.push_back('{cyc, int'(ResultChan), int'(ResultFreq), int'(Busy)});
        if (CntEn === 1'b1 && en_prev !== 1'b1) begin
            clr_q.push_back(clr_run);
            sel_q.push_back(int'(SigSel));
        end
        if (CntEn === 1'b1) en_run++;
        else begin
            if (en_prev === 1'b1) gate_q.push_back(en_run);
            en_run = 0;
        end
        if (CntClr === 1'b1 && Busy === 1'b1) clr_run++;
        else clr_run = 0;
        en_prev = CntEn;
    endtask

    task automatic clear_mon();
        sq.delete();
        gate_q.delete();
        clr_q.delete();
        sel_q.delete();
        en_run  = 0;
        clr_run = 0;
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] mask, output int t0);
        ChanMask = mask;
        Start    = 1'b1;
        t0       = cyc + 1;
        tick();
        Start    = 1'b0;
    endtask

    // Sweep of `passes` passes over mask; Continuous is dropped after strobe (passes-1)*n+drop_j
    task automatic run_sweep(input logic [NUM_CH-1:0] mask, input int passes, input int drop_j,
                             input bit noise);
        int ch[$];
        int n, t0, exp_n, budget, m;
        for (int i = 0; i < NUM_CH; i++) if (mask[i]) ch.push_back(i);
        n = ch.size();
        clear_mon();
        Continuous = (passes > 1);
        pulse_start(mask, t0);
        exp_n  = passes * n;
        budget = exp_n * SPACE + 20;
        while (sq.size() < exp_n && budget > 0) begin
            if (passes > 1 && sq.size() >= (passes - 1) * n + drop_j) Continuous = 1'b0;
            if (noise && passes == 1) ChanMask = NUM_CH'($urandom);
            Start = (noise && $urandom_range(0, 19) == 0);
            tick();
            budget--;
        end
        Start      = 1'b0;
        Continuous = 1'b0;
        repeat (SPACE + 5) tick();
        check("strobe_count", sq.size(), exp_n);
        check("busy_after_sweep", Busy, 1'b0);
        m = (sq.size() < exp_n) ? sq.size() : exp_n;
        for (int k = 0; k < m; k++) begin
            check("strobe_cycle", sq[k].cyc, t0 + LAT - 1 + k * SPACE);
            check("result_chan", sq[k].chan, ch[k % n]);
            check("result_freq", sq[k].freq, G);
            check("busy_at_strobe", sq[k].busy, (k == exp_n - 1) ? 0 : 1);
        end
        check("gate_count", gate_q.size(), exp_n);
        for (int k = 0; k < gate_q.size() && k < exp_n; k++) begin
            check("gate_len", gate_q[k], G);
            check("clr_before_gate", clr_q[k], S + 1);
            check("sigsel_in_gate", sel_q[k], ch[k % n]);
        end
    endtask

    // Stop asserted during the k-th gate cycle
    task automatic run_stop(input logic [NUM_CH-1:0] mask, input int k);
        int t0;
        logic [CNT_W-1:0] prev_freq;
        clear_mon();
        prev_freq  = ResultFreq;
        Continuous = 1'($urandom_range(0, 1));
        pulse_start(mask, t0);
        while (cyc < t0 + 2 + k) tick();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check("stop_busy", Busy, 1'b0);
        check("stop_clr", CntClr, 1'b1);
        check("stop_en", CntEn, 1'b0);
        repeat (SPACE + 5) tick();
        Continuous = 1'b0;
        check("stop_no_strobe", sq.size(), 0);
        check("stop_freq_held", ResultFreq, prev_freq);
        check("stop_gate_windows", gate_q.size(), 1);
        if (gate_q.size() > 0) check("stop_gate_len", gate_q[0], k);
    endtask

    initial begin
        int t0;
        logic [NUM_CH-1:0] mask;
        int passes;
        Rst = 1'b1; Start = 1'b0; Stop = 1'b0; Continuous = 1'b0; ChanMask = 4'b0000;
        repeat (2) tick();
        Rst = 1'b0;
        repeat (5) tick();
        check("rst_clr", CntClr, 1'b1);
        check("rst_en", CntEn, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_valid", ResultValid, 1'b0);
        check("rst_freq", ResultFreq, 32'd0);
        check("rst_chan", ResultChan, 2'd0);
        check("rst_sigsel", SigSel, 2'd0);

        run_sweep(4'b0001, 1, 0, 1'b0);
        run_sweep(4'b1010, 1, 0, 1'b0);
        run_sweep(4'b0101, 2, 1, 1'b0);
        run_stop(4'b0110, 5);

        // Start with an empty mask is ignored
        clear_mon();
        pulse_start(4'b0000, t0);
        repeat (20) tick();
        check("empty_mask_busy", Busy, 1'b0);
        check("empty_mask_gates", gate_q.size(), 0);

        // Stop and Start together in IDLE: stay idle
        clear_mon();
        ChanMask = 4'b0011; Start = 1'b1; Stop = 1'b1;
        tick();
        Start = 1'b0; Stop = 1'b0;
        repeat (20) tick();
        check("stop_start_busy", Busy, 1'b0);
        check("stop_start_gates", gate_q.size(), 0);

        // Reset in the middle of a gate window
        clear_mon();
        pulse_start(4'b1000, t0);
        while (cyc < t0 + 3 + 4) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("midrst_sigsel", SigSel, 2'd0);
        check("midrst_clr", CntClr, 1'b1);
        check("midrst_en", CntEn, 1'b0);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_valid", ResultValid, 1'b0);
        check("midrst_chan", ResultChan, 2'd0);
        check("midrst_freq", ResultFreq, 32'd0);
        repeat (SPACE + 5) tick();
        check("midrst_no_strobe", sq.size(), 0);

        for (int it = 0; it < 14; it++) begin
            mask   = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            passes = $urandom_range(1, 3);
            run_sweep(mask, passes, $urandom_range(0, $countones(mask) - 1), 1'b1);
        end
        for (int it = 0; it < 4; it++) begin
            run_stop(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), $urandom_range(1, G));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/freq_meas_sequencer.md
Name: freq_meas_sequencer

Overview:
Sequences the shared frequency-counter datapath across NUM_CH input signals. Selects one signal through an external mux (SigSel), holds the counter clear while the mux settles, opens a gate window of exactly GATE_CYCLES clocks, then captures the count and reports it with its channel number. It sits between the host/control logic and the single counter instance, sweeping the enabled channels one at a time or continuously.

Parameters:
NUM_CH, 4, number of signal channels sharing the counter (2..16)
CH_W, 2, width of channel index, equals clog2(NUM_CH)
CNT_W, 32, counter/result width
GATE_CYCLES, 100000000, gate window length in Clk cycles (1 s at 100 MHz); must be >= 1
SETTLE_CYCLES, 2, cycles counter held clear after a mux change; must be >= 1

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  synchronous, active-high reset
Start  in  1  one-cycle request to begin a sweep
Stop  in  1  abort request
Continuous  in  1  1 = restart the sweep after the last enabled channel
ChanMask  in  NUM_CH  channel enables, bit i = channel i
SigSel  out  CH_W  mux select to the counter input
CntClr  out  1  counter synchronous clear
CntEn  out  1  counter gate enable
CntVal  in  CNT_W  counter value from the datapath
Busy  out  1  sweep in progress
ResultValid  out  1  one-cycle strobe, result fields valid
ResultChan  out  CH_W  channel of the last result
ResultFreq  out  CNT_W  edge count over the gate window

Behaviour:
- Reset (Rst=1 at an edge, any state): state IDLE. SigSel=0, CntClr=1, CntEn=0, Busy=0, ResultValid=0, ResultChan=0, ResultFreq=0. Mask latch=0. A measurement in flight is discarded with no strobe.
- States: IDLE, SELECT, SETTLE, GATE, CAPTURE. All outputs are registered.
- IDLE: CntClr=1, CntEn=0, Busy=0. Start=1 with ChanMask!=0 latches ChanMask and moves to SELECT on the lowest set bit. Start with ChanMask==0 is ignored.
- SELECT (1 cycle): drive SigSel=channel, CntClr=1, Busy=1. Then go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): CntClr=1, CntEn=0. Then go to GATE.
- GATE (exactly GATE_CYCLES cycles): CntClr=0, CntEn=1. Use an internal 32-bit down-counter. Then go to CAPTURE.
- CAPTURE (1 cycle): CntEn=0. At the end of this cycle, ResultFreq<=CntVal and ResultChan<=SigSel. ResultValid=1 for exactly the next cycle.
- After CAPTURE, go to the next higher set bit of the latched mask, through SELECT. This SELECT runs in the same cycle as ResultValid.
- No higher set bit left: if Continuous=1 and the live ChanMask!=0, re-latch ChanMask and go to its lowest bit. Otherwise go to IDLE, with Busy=0 in the ResultValid cycle.
- Latency: Start sampled at edge 0 gives ResultValid in cycle 3+SETTLE_CYCLES+GATE_CYCLES. Consecutive results are spaced 2+SETTLE_CYCLES+GATE_CYCLES cycles apart.
- Start while Busy=1 is ignored. ChanMask changes mid-sweep take effect only at the next sweep start.
- Continuous dropped mid-sweep: the current sweep completes, then IDLE.
- Stop=1 in any non-IDLE state: IDLE on the next edge, no ResultValid, result registers unchanged, CntClr=1. Stop and Start in the same IDLE cycle: Stop wins, stay IDLE. Rst has priority over everything.
- CntVal is passed through unmodified; saturation and wrap are the counter's responsibility.

Test Plan:
Common setup: NUM_CH=4, GATE_CYCLES=10, SETTLE_CYCLES=2, Clk period 10 ns. The bench counter model increments on each CntEn cycle and clears on CntClr.
1. Reset, then idle 5 cycles -> CntClr=1, CntEn=0, Busy=0, ResultValid=0, ResultFreq=0.
2. ChanMask=4'b0001, Start pulse, Continuous=0 -> ResultValid in cycle 15 after Start, ResultChan=0, ResultFreq=10. CntEn high exactly 10 cycles. Busy=0 from the strobe cycle.
3. ChanMask=4'b1010, Start -> two strobes 14 cycles apart, ResultChan=1 then 3, each ResultFreq=10. SigSel steps 1 then 3, and CntClr is high 3 cycles before each gate.
4. ChanMask=4'b0101, Continuous=1; drop Continuous after the 3rd strobe -> ResultChan sequence 0,2,0,2, then IDLE.
5. Start, then Stop in the 5th GATE cycle -> IDLE next cycle, no ResultValid, ResultFreq holds its previous value. A Start with ChanMask=0 produces no activity.
6. Rst asserted mid-GATE -> all outputs at reset values on the next edge. Start during Busy=1 is ignored, with no extra strobe.
